spi_shift_unit: RTL



---
 rtl/spi_shift_unit_pkg.sv | 23 ++
 rtl/spi_bit_counter.sv | 45 ++++
 rtl/spi_shift_unit.sv | 75 +++++++
 3 files changed

// File: rtl/spi_shift_unit_pkg.sv
// rtl/spi_shift_unit_pkg.sv - shared SR_WE encodings and frame constants for the SPI shift unit and FSM
package spi_shift_unit_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 3;

  // Shift register command issued by the control FSM; 2'b11 is reserved and acts as hold
  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_LOAD  = 2'b01,
    SR_CLEAR = 2'b10,
    SR_RSVD  = 2'b11
  } sr_we_e;

  // Value of the R/W bit that marks a read transaction
  localparam logic READ = 1'b1;

  // True when the command lets a normal serial shift proceed
  function automatic logic shift_allowed(input logic [1:0] cmd);
    return (cmd != SR_LOAD) && (cmd != SR_CLEAR);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - bit counter, byte-complete pulse and address/data byte index
module spi_bit_counter
  import spi_shift_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             shift,
  output logic [CNT_W-1:0] bit_count,
  output logic             byte_done,
  output logic             byte_index
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Count shifted bits, pulse byte_done one clk after the last bit, track address vs data byte
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count  <= '0;
      byte_done  <= 1'b0;
      byte_index <= 1'b0;
    end else if (cs) begin
      bit_count  <= '0;
      byte_done  <= 1'b0;
      byte_index <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (shift) begin
        if (bit_count == LAST_BIT) begin
          bit_count <= '0;
          byte_done <= 1'b1;
        end else begin
          bit_count <= bit_count + 1'b1;
        end
      end
      if (byte_done) begin
        byte_index <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_shift_unit.sv
// rtl/spi_shift_unit.sv - SPI byte assembler, R/W latch and MISO shifter feeding the control FSM
module spi_shift_unit
  import spi_shift_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_pos,
  input  logic             sclk_neg,
  input  logic             mosi,
  input  logic             cs,
  input  logic [1:0]       sr_we,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             rw_bit,
  output logic             byte_done,
  output logic [CNT_W-1:0] bit_count,
  output logic             miso
);

  logic shift;
  logic byte_index;

  // A load or clear in the same cycle as an SCLK rising edge wins and the shift is dropped
  assign shift = !cs && sclk_pos && shift_allowed(sr_we);

  spi_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .shift      (shift),
    .bit_count  (bit_count),
    .byte_done  (byte_done),
    .byte_index (byte_index)
  );

  // Shift register: held while deselected so the FSM can read it after the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      parallel_out <= '0;
    end else if (!cs) begin
      if (sr_we == SR_CLEAR) begin
        parallel_out <= '0;
      end else if (sr_we == SR_LOAD) begin
        parallel_out <= parallel_in;
      end else if (sclk_pos) begin
        parallel_out <= {parallel_out[WIDTH-2:0], mosi};
      end
    end
  end

  // Latch the last bit of the address byte as R/W; data bytes leave it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_bit <= 1'b0;
    end else if (!cs && byte_done && !byte_index) begin
      rw_bit <= parallel_out[0];
    end
  end

  // MISO presents the pre-shift MSB on each SCLK falling edge, holds while deselected
  always_ff @(posedge clk) begin
    if (reset) begin
      miso <= 1'b0;
    end else if (!cs && sclk_neg) begin
      miso <= parallel_out[WIDTH-1];
    end
  end

endmodule
